// File: rtl/ysyx_24100012_lsu.sv
// rtl/ysyx_24100012_lsu.sv - load/store unit between execute stage and the data RAM
module ysyx_24100012_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wen,
    output logic                  mem_ren,
    output logic [DATA_WIDTH-1:0] mem_len,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t                state;
    logic                  wen_r;
    logic [2:0]            funct3_r;
    logic [3:0]            cnt;

    logic                  illegal;
    logic                  misaligned;
    logic [DATA_WIDTH-1:0] len_val;
    logic [DATA_WIDTH-1:0] wdata_masked;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // Funct3 6/7 and 3 are never legal; stores have no unsigned variants.
    always_comb begin
        illegal    = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11) ||
                     (req_wen && req_funct3[2]);
        misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        len_val      = '0;
        wdata_masked = '0;
        case (req_funct3[1:0])
            2'd0: begin
                len_val      = {{(DATA_WIDTH-3){1'b0}}, 3'd1};
                wdata_masked = {{(DATA_WIDTH-8){1'b0}}, req_wdata[7:0]};
            end
            2'd1: begin
                len_val      = {{(DATA_WIDTH-3){1'b0}}, 3'd2};
                wdata_masked = {{(DATA_WIDTH-16){1'b0}}, req_wdata[15:0]};
            end
            default: begin
                len_val      = {{(DATA_WIDTH-3){1'b0}}, 3'd4};
                wdata_masked = req_wdata;
            end
        endcase
    end

    always_comb begin
        ext_rdata = mem_rdata;
        case (funct3_r)
            3'd0:    ext_rdata = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
            3'd1:    ext_rdata = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
            3'd4:    ext_rdata = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
            3'd5:    ext_rdata = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
            default: ext_rdata = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wen_r      <= 1'b0;
            funct3_r   <= 3'd0;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_wen    <= 1'b0;
            mem_ren    <= 1'b0;
            mem_len    <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_raddr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_r     <= req_wen;
                        funct3_r  <= req_funct3;
                        req_ready <= 1'b0;
                        if (illegal || misaligned) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            cnt       <= CNT_INIT;
                            mem_len   <= len_val;
                            mem_waddr <= req_addr;
                            mem_raddr <= req_addr;
                            mem_wdata <= wdata_masked;
                            mem_wen   <= req_wen;
                            mem_ren   <= !req_wen;
                        end
                    end
                end
                ACCESS: begin
                    // One write strobe per store regardless of access length.
                    mem_wen <= 1'b0;
                    if (cnt == 4'd0) begin
                        mem_ren    <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wen_r ? '0 : ext_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100012_lsu.sv
// tb/tb_ysyx_24100012_lsu.sv - LSU bench: three latencies in lockstep against a byte-level memory model
module tb_ysyx_24100012_lsu;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready  [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];
    logic        mem_wen    [NI];
    logic        mem_ren    [NI];
    logic [31:0] mem_len    [NI];
    logic [31:0] mem_waddr  [NI];
    logic [31:0] mem_wdata  [NI];
    logic [31:0] mem_raddr  [NI];

    bit          fz;
    logic [31:0] fv;
    bit   [7:0]  mram [256];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bit   [7:0]  ram [256];
        logic [31:0] rd;

        ysyx_24100012_lsu #(
            .ADDR_WIDTH(32),
            .DATA_WIDTH(32),
            .LATENCY   (g == 0 ? 1 : (g == 1 ? 3 : 4))
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (req_ready[g]),
            .req_wen   (req_wen),
            .req_funct3(req_funct3),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .mem_wen   (mem_wen[g]),
            .mem_ren   (mem_ren[g]),
            .mem_len   (mem_len[g]),
            .mem_waddr (mem_waddr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_raddr (mem_raddr[g]),
            .mem_rdata (rd)
        );

        always_comb begin
            rd = '0;
            for (int b = 0; b < 4; b++)
                if (b < int'(mem_len[g])) rd[8*b +: 8] = ram[8'(mem_raddr[g] + 32'(b))];
            if (fz) rd = fv;
        end

        always @(posedge clk) begin
            if (mem_wen[g])
                for (int b = 0; b < 4; b++)
                    if (b < int'(mem_len[g])) ram[8'(mem_waddr[g] + 32'(b))] <= mem_wdata[g][8*b +: 8];
        end
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s dut%0d observed=%h expected=%h", tag, i, obs, exp);
    endtask

    // Reference behaviour: RISC-V access rules over a flat byte memory.
    task automatic model(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic err, output logic [31:0] rdv, output int sz, output logic [31:0] wmask);
        logic [31:0] word;
        sz    = 1 << (f3 % 4);
        err   = (f3 == 3) || (f3 >= 6) || (w && f3 >= 4) || ((a % sz) != 0);
        wmask = (sz >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        rdv   = 0;
        if (!err && w) begin
            for (int b = 0; b < sz; b++) mram[8'(a + 32'(b))] = 8'(wd >> (8 * b));
        end else if (!err) begin
            word = 0;
            for (int b = 0; b < sz; b++) word = word | (32'(mram[8'(a + 32'(b))]) << (8 * b));
            if (fz) word = fv;
            case (f3)
                3'd0: begin rdv = word % 256;   if (rdv >= 128)   rdv = rdv - 256;   end
                3'd1: begin rdv = word % 65536; if (rdv >= 32768) rdv = rdv - 65536; end
                3'd4: rdv = word % 256;
                3'd5: rdv = word % 65536;
                default: rdv = word;
            endcase
        end
    endtask

    task automatic transact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int hold);
        logic        err;
        logic [31:0] rdv;
        logic [31:0] wmask;
        int          sz;
        int          first [NI];
        int          wens  [NI];
        int          rens  [NI];
        int          rdy_k [NI];
        bit          fin   [NI];
        int          nfin;
        model(w, f3, a, wd, err, rdv, sz, wmask);
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        for (int i = 0; i < NI; i++) begin
            chk("req_ready_idle", i, 32'(req_ready[i]), 1);
            first[i] = -1; wens[i] = 0; rens[i] = 0; rdy_k[i] = -1; fin[i] = 0;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        nfin = 0;
        for (int k = 0; k < 60 && nfin < NI; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (fin[i]) continue;
                if (rdy_k[i] >= 0) begin
                    chk("resp_valid_after_hs", i, 32'(resp_valid[i]), 0);
                    chk("req_ready_after_hs", i, 32'(req_ready[i]), 1);
                    resp_ready[i] = 1'b0;
                    fin[i] = 1;
                    nfin++;
                    continue;
                end
                if (mem_wen[i]) begin
                    wens[i]++;
                    chk("mem_len_wr", i, mem_len[i], sz);
                    chk("mem_wdata", i, mem_wdata[i], wd & wmask);
                    chk("mem_waddr", i, mem_waddr[i], a);
                end
                if (mem_ren[i]) begin
                    rens[i]++;
                    chk("mem_len_rd", i, mem_len[i], sz);
                    chk("mem_raddr", i, mem_raddr[i], a);
                end
                if (resp_valid[i]) begin
                    if (first[i] < 0) begin
                        first[i] = k;
                        chk("resp_latency", i, k + 1, err ? 1 : lat(i) + 1);
                    end
                    chk("resp_rdata", i, resp_rdata[i], rdv);
                    chk("resp_err", i, 32'(resp_err[i]), 32'(err));
                    chk("req_ready_resp", i, 32'(req_ready[i]), 0);
                    if (k - first[i] >= hold) begin
                        chk("wen_cycles", i, wens[i], (w && !err) ? 1 : 0);
                        chk("ren_cycles", i, rens[i], (!w && !err) ? lat(i) : 0);
                        resp_ready[i] = 1'b1;
                        rdy_k[i] = k;
                    end
                end else begin
                    chk("req_ready_busy", i, 32'(req_ready[i]), 0);
                end
            end
            @(negedge clk);
        end
        for (int i = 0; i < NI; i++)
            if (!fin[i]) begin
                chk("timeout", i, 0, 1);
                resp_ready[i] = 1'b0;
            end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        fz         = 1'b0;
        fv         = 32'd0;
        for (int i = 0; i < NI; i++) resp_ready[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_req_ready", i, 32'(req_ready[i]), 1);
            chk("rst_resp_valid", i, 32'(resp_valid[i]), 0);
            chk("rst_resp_rdata", i, resp_rdata[i], 0);
            chk("rst_resp_err", i, 32'(resp_err[i]), 0);
            chk("rst_mem_wen", i, 32'(mem_wen[i]), 0);
            chk("rst_mem_ren", i, 32'(mem_ren[i]), 0);
            chk("rst_mem_len", i, mem_len[i], 0);
            chk("rst_mem_waddr", i, mem_waddr[i], 0);
        end
        rst = 1'b0;

        transact(1'b1, 3'd2, 32'h8000_0100, 32'hDEAD_BEEF, 0);
        transact(1'b0, 3'd2, 32'h8000_0100, 32'h0, 0);

        fz = 1'b1; fv = 32'h0000_00F0;
        transact(1'b0, 3'd0, 32'h8000_0010, 32'h0, 0);
        transact(1'b0, 3'd4, 32'h8000_0010, 32'h0, 0);
        fv = 32'h0000_8001;
        transact(1'b0, 3'd1, 32'h8000_0010, 32'h0, 0);
        transact(1'b0, 3'd5, 32'h8000_0010, 32'h0, 0);
        fz = 1'b0;

        transact(1'b0, 3'd2, 32'h8000_0102, 32'h0, 0);
        transact(1'b1, 3'd4, 32'h8000_0104, 32'h1111_2222, 0);
        transact(1'b0, 3'd2, 32'h8000_0100, 32'h0, 5);
        transact(1'b1, 3'd0, 32'h8000_0020, 32'h1234_5678, 1);

        for (int n = 0; n < 16; n++)
            transact(1'b1, 3'd2, 32'h8000_0000 | 32'(4 * $urandom_range(0, 63)), $urandom, 0);
        for (int n = 0; n < 50; n++)
            transact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 3));

        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h8000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("ren_before_rst", 1, 32'(mem_ren[1]), 1);
        chk("ren_before_rst", 2, 32'(mem_ren[2]), 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_rst_ren", i, 32'(mem_ren[i]), 0);
            chk("async_rst_wen", i, 32'(mem_wen[i]), 0);
            chk("async_rst_resp_valid", i, 32'(resp_valid[i]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("post_rst_req_ready", i, 32'(req_ready[i]), 1);
            chk("post_rst_resp_valid", i, 32'(resp_valid[i]), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_lsu.md
Name: ysyx_24100012_lsu

Overview:
Load/store unit directly upstream of the DPI-backed data RAM. It takes one memory request at a time from the execute stage over a valid/ready handshake and drives the RAM's write-enable, read-enable, length, address and data ports. It captures the RAM's right-justified read data and sign- or zero-extends it. It returns the result to writeback over a second valid/ready handshake, and flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width; also the width of mem_len.
LATENCY, 1, cycles the RAM access phase lasts (legal range 1..15); read data is sampled on the last cycle.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  request offered.
req_ready  out  1  LSU can accept a request.
req_wen  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V size/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  DATA_WIDTH  store data, right-justified.
resp_valid  out  1  response available.
resp_ready  in  1  consumer takes response.
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned or illegal request.
mem_wen  out  1  RAM write enable.
mem_ren  out  1  RAM read enable.
mem_len  out  DATA_WIDTH  access length in bytes (1/2/4).
mem_waddr  out  ADDR_WIDTH  RAM write address.
mem_wdata  out  DATA_WIDTH  RAM write data, right-justified.
mem_raddr  out  ADDR_WIDTH  RAM read address.
mem_rdata  in  DATA_WIDTH  RAM read data (combinational, right-justified).

Behaviour:
- Single clock. Reset is asynchronous and active-high on rst.
- While rst is high: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_ren=0, mem_len=0, mem_waddr=0, mem_wdata=0, mem_raddr=0, wait counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at edge N: register wen, funct3, addr and wdata.
  - Legality check:
    - Illegal funct3: 3, 6, 7, or a store with 4/5.
    - Misaligned: size 2 with addr[0]=1, or size 4 with addr[1:0]!=0.
  - Illegal or misaligned -> RESP with resp_err=1, resp_rdata=0; no RAM strobe ever asserted.
  - Otherwise -> ACCESS; counter loads LATENCY-1.
- ACCESS:
  - req_ready=0.
  - mem_len = 1/2/4 from funct3[1:0]. Address ports carry the registered address; mem_wdata carries registered wdata masked to the size.
  - Load: mem_ren=1 for all LATENCY cycles.
  - Store: mem_wen=1 only in the first ACCESS cycle, so exactly one DPI write per store.
  - Counter decrements each cycle. When it is 0: load captures mem_rdata, extended per funct3 (LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW passthrough). Then -> RESP.
  - Outside ACCESS, mem_wen=mem_ren=0 and addresses/len hold their last value.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_valid&resp_ready.
  - On handshake -> IDLE. Stores return resp_rdata=0, resp_err=0.
- Latency: accept at edge N -> resp_valid high from cycle N+LATENCY+1. Error path -> resp_valid at N+1.
- Throughput: one request in flight. A new request can be accepted no earlier than the cycle after the response handshake.
- req_valid during ACCESS/RESP is ignored (req_ready=0); the requester must hold it.
- resp_ready held high in RESP -> single-cycle response.
- rst asserted mid-ACCESS or mid-RESP: strobes and resp_valid drop immediately (asynchronous). The transaction is lost with no response. A store already strobed is not undone.
- Byte addressing: addr is passed unmodified; the RAM handles byte offset and length.

Test Plan:
- Reset: rst=1 mid-ACCESS with LATENCY=3 -> mem_ren and mem_wen go 0 without waiting for a clock edge; after release, req_ready=1 and resp_valid=0.
- SW then LW: store addr 0x80000100, wdata 0xDEADBEEF, LATENCY=1 -> mem_wen high exactly 1 cycle with mem_len=4. Load of the same address -> resp_rdata=0xDEADBEEF, resp_valid at N+2.
- Sign extension: RAM returns 0x000000F0 -> LB gives 0xFFFFFFF0, LBU gives 0x000000F0. RAM returns 0x00008001 -> LH gives 0xFFFF8001, LHU gives 0x00008001.
- Misaligned LW at 0x80000102 -> resp_err=1 and resp_rdata=0 at N+1; mem_ren never asserted. Store with funct3=4 -> resp_err=1.
- Backpressure: LATENCY=4 load with resp_ready=0 for 5 cycles -> resp_valid and data held stable, req_ready=0; new req_valid not accepted until the cycle after the handshake.
- Store masking: SB with wdata 0x12345678 -> mem_wdata=0x00000078, mem_len=1, single-cycle mem_wen even with LATENCY=3.
